// File: rtl/codeword_bit_counter.sv
// Bit-slot sequencer for one N-bit codeword: steps 0..N-1, flags message/parity
// phases, supports stall, abort, continuous framing and a completed-frame count.
//
// state | meaning
// IDLE  | waiting for start, count held at 0
// RUN   | stepping through codeword slots
module codeword_bit_counter #(
  parameter int N  = 31,
  parameter int K  = 21,
  parameter int FW = 8,
  localparam int W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          stall_i,
  input  logic          abort_i,
  input  logic          continuous_i,
  output logic [W-1:0]  count_o,
  output logic          busy_o,
  output logic          msg_phase_o,
  output logic          par_phase_o,
  output logic          last_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [FW-1:0] frame_cnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [W-1:0] LAST_CNT = W'(N - 1);
  // One extra bit so K == N (which may equal 2^W) still compares correctly.
  localparam logic [W:0]   K_CMP    = (W + 1)'(K);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          in_msg;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start_i && !abort_i) state_d = RUN;
      end
      RUN: begin
        if (abort_i) begin
          state_d   = IDLE;
          count_d   = '0;
          aborted_d = 1'b1;
        end else if (stall_i) begin
          count_d = count_q;
        end else if (count_q != LAST_CNT) begin
          count_d = count_q + W'(1);
        end else begin
          frame_d = frame_q + FW'(1);
          done_d  = 1'b1;
          count_d = '0;
          if (!continuous_i) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign in_msg      = {1'b0, count_q} < K_CMP;
  assign busy_o      = (state_q == RUN);
  assign msg_phase_o = busy_o && in_msg;
  assign par_phase_o = busy_o && !in_msg;
  assign last_o      = busy_o && (count_q == LAST_CNT);
  assign count_o     = count_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign frame_cnt_o = frame_q;

endmodule

// File: tb/tb_codeword_bit_counter.sv
// Directed bench for codeword_bit_counter: default (31,21,8) instance plus a
// small (7,7,2) instance for the K==N and frame counter wrap corners.
module tb_codeword_bit_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 0, stall = 0, abort = 0, cont = 0;
  logic [4:0] count;
  logic       busy, msg, par, last, done, aborted;
  logic [7:0] frame;

  logic       b_start = 0, b_stall = 0, b_abort = 0, b_cont = 0;
  logic [2:0] b_count;
  logic       b_busy, b_msg, b_par, b_last, b_done, b_aborted;
  logic [1:0] b_frame;

  int vec_cnt = 0;
  int err_cnt = 0;

  codeword_bit_counter #(.N(31), .K(21), .FW(8)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .stall_i(stall), .abort_i(abort),
    .continuous_i(cont), .count_o(count), .busy_o(busy), .msg_phase_o(msg),
    .par_phase_o(par), .last_o(last), .done_o(done), .aborted_o(aborted),
    .frame_cnt_o(frame)
  );

  codeword_bit_counter #(.N(7), .K(7), .FW(2)) u_small (
    .clk(clk), .rst(rst), .start_i(b_start), .stall_i(b_stall), .abort_i(b_abort),
    .continuous_i(b_cont), .count_o(b_count), .busy_o(b_busy), .msg_phase_o(b_msg),
    .par_phase_o(b_par), .last_o(b_last), .done_o(b_done), .aborted_o(b_aborted),
    .frame_cnt_o(b_frame)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame", frame, 0);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state, all outputs low
    #1;
    check("por_count", count, 0);
    check("por_busy", busy, 0);
    check("por_msg", msg, 0);
    check("por_par", par, 0);
    check("por_last", last, 0);
    check("por_done", done, 0);
    check("por_aborted", aborted, 0);
    check("por_frame", frame, 0);
    do_reset();

    // One-shot frame
    pulse_start();
    for (int i = 0; i < 31; i++) begin
      check("os_count", count, i);
      check("os_busy", busy, 1);
      check("os_msg", msg, (i < 21) ? 1 : 0);
      check("os_par", par, (i >= 21) ? 1 : 0);
      check("os_last", last, (i == 30) ? 1 : 0);
      check("os_done", done, 0);
      tick();
    end
    check("os_done_end", done, 1);
    check("os_busy_end", busy, 0);
    check("os_frame_end", frame, 1);
    check("os_count_end", count, 0);
    // Restart in the same cycle done is high
    pulse_start();
    check("restart_busy", busy, 1);
    check("restart_count", count, 0);
    check("restart_done", done, 0);

    // Continuous, three frames
    do_reset();
    cont = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 31; i++) begin
        check("ct_count", count, i);
        check("ct_busy", busy, 1);
        check("ct_done", done, (i == 0 && f > 0) ? 1 : 0);
        if (f == 2 && i == 30) cont = 1'b0;
        tick();
      end
    end
    check("ct_done_end", done, 1);
    check("ct_busy_end", busy, 0);
    check("ct_frame_end", frame, 3);

    // Stall 4 cycles at count 10, 2 cycles at count 30
    do_reset();
    pulse_start();
    for (int c = 0; c < 37; c++) begin
      int exp_c;
      exp_c = (c <= 10) ? c : (c <= 14) ? 10 : (c <= 34) ? c - 4 : 30;
      check("st_count", count, exp_c);
      check("st_busy", busy, 1);
      check("st_done", done, 0);
      stall = ((c >= 10 && c <= 13) || c == 34 || c == 35);
      tick();
    end
    stall = 1'b0;
    check("st_done_end", done, 1);
    check("st_busy_end", busy, 0);
    check("st_frame_end", frame, 1);
    tick();
    check("st_done_clear", done, 0);

    // Abort at count 15
    do_reset();
    pulse_start();
    for (int c = 0; c < 15; c++) tick();
    check("ab_pre_count", count, 15);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_count", count, 0);
    check("ab_aborted", aborted, 1);
    check("ab_done", done, 0);
    check("ab_frame", frame, 0);
    // Abort coincident with last slot, with a start accepted right after abort
    pulse_start();
    check("ab_clear", aborted, 0);
    for (int c = 0; c < 30; c++) tick();
    check("abl_last", last, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abl_done", done, 0);
    check("abl_aborted", aborted, 1);
    check("abl_frame", frame, 0);
    check("abl_busy", busy, 0);
    // Abort in IDLE, then start+abort together
    abort = 1'b1;
    tick();
    check("idle_abort", aborted, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);

    // Async reset mid-frame at count 12
    pulse_start();
    for (int c = 0; c < 12; c++) tick();
    check("ar_pre_count", count, 12);
    #2 rst = 1'b1;
    #1;
    check("ar_count", count, 0);
    check("ar_busy", busy, 0);
    check("ar_msg", msg, 0);
    check("ar_done", done, 0);
    check("ar_aborted", aborted, 0);
    rst = 1'b0;
    tick();
    pulse_start();
    check("ar_restart_busy", busy, 1);
    check("ar_restart_count", count, 0);

    // Small instance: K==N never in parity phase; FW=2 wraps 1,2,3,0,1
    b_cont = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 7; i++) begin
        check("sm_count", b_count, i);
        check("sm_par", b_par, 0);
        check("sm_msg", b_msg, 1);
        if (i == 0) check("sm_frame", b_frame, f % 4);
        if (f == 4 && i == 6) b_cont = 1'b0;
        tick();
      end
    end
    check("sm_frame_end", b_frame, 1);
    check("sm_done_end", b_done, 1);
    check("sm_busy_end", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
